// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard scoreboard: forward-select codes
// and the supported load-latency window.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_W  = 2'd1,
        FWD_M  = 2'd2
    } fwdSel_t;

    localparam int LD_LAT_MIN = 1;
    localparam int LD_LAT_MAX = 7;

endpackage

// File: rtl/hazard_scoreboard_sb_counter.sv
// Per-register load-latency down-counter. A load always wins over a
// same-cycle decrement, so a re-issued load restarts the full latency.
module sb_counter #(
    parameter int CW       = 1,
    parameter int LOAD_VAL = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic decEn,
    output logic zero
);

    logic [CW-1:0] countReg;

    always_ff @(posedge clk) begin
        if (reset) begin
            countReg <= '0;
        end else if (load) begin
            countReg <= CW'(LOAD_VAL);
        end else if (decEn && countReg != '0) begin
            countReg <= countReg - CW'(1);
        end
    end

    assign zero = (countReg == '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard unit for a five-stage pipeline: operand forwarding, load-use stalls
// tracked by a per-register scoreboard, redirect flushes and miss freezes.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int NREG   = 32,
    parameter int AW     = $clog2(NREG),
    parameter int LD_LAT = 1,
    parameter int SCW    = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [AW-1:0]   rs1_d,
    input  logic [AW-1:0]   rs2_d,
    input  logic [AW-1:0]   rd_d,
    input  logic            is_load_d,
    input  logic [AW-1:0]   rs1_e,
    input  logic [AW-1:0]   rs2_e,
    input  logic [AW-1:0]   rd_m,
    input  logic [AW-1:0]   rd_w,
    input  logic            regwrite_m,
    input  logic            regwrite_w,
    input  logic            pcsrc_e,
    input  logic            miss,
    output logic [1:0]      fwd_a_e,
    output logic [1:0]      fwd_b_e,
    output logic            stall_f,
    output logic            stall_d,
    output logic            stall_e,
    output logic            stall_m,
    output logic            flush_d,
    output logic            flush_e,
    output logic [NREG-1:0] pending,
    output logic [SCW-1:0]  stall_cycles
);

    // Out-of-range latencies are clamped rather than silently wrapping.
    localparam int LAT = (LD_LAT < LD_LAT_MIN) ? LD_LAT_MIN :
                         (LD_LAT > LD_LAT_MAX) ? LD_LAT_MAX : LD_LAT;
    localparam int CW  = $clog2(LAT + 1);

    logic [NREG-1:0] pendingVec;
    logic            ldStall;
    logic            rawStallD;
    logic            issue;
    logic [SCW-1:0]  stallCyclesReg;

    function automatic fwdSel_t fwdSelect(input logic [AW-1:0] rs,
                                          input logic [AW-1:0] rdM,
                                          input logic [AW-1:0] rdW,
                                          input logic          wrM,
                                          input logic          wrW);
        if (rs != '0 && wrM && rs == rdM) begin
            return FWD_M;
        end else if (rs != '0 && wrW && rs == rdW) begin
            return FWD_W;
        end
        return FWD_RF;
    endfunction

    // x0 never holds a pending load.
    assign pendingVec[0] = 1'b0;

    generate
        for (genvar gi = 1; gi < NREG; gi++) begin : genCnt
            logic cntZero;
            sb_counter #(
                .CW       (CW),
                .LOAD_VAL (LAT)
            ) uCounter (
                .clk   (clk),
                .reset (reset),
                .load  (issue && rd_d == AW'(gi)),
                .decEn (~miss),
                .zero  (cntZero)
            );
            assign pendingVec[gi] = ~cntZero;
        end
    endgenerate

    assign ldStall   = (rs1_d != '0 && pendingVec[rs1_d]) ||
                       (rs2_d != '0 && pendingVec[rs2_d]);
    assign rawStallD = ldStall | miss;
    // A redirect squashes the decode slot, so a squashed load never enters the scoreboard.
    assign issue     = is_load_d & (rd_d != '0) & ~rawStallD & ~pcsrc_e;

    assign fwd_a_e = reset ? FWD_RF : fwdSelect(rs1_e, rd_m, rd_w, regwrite_m, regwrite_w);
    assign fwd_b_e = reset ? FWD_RF : fwdSelect(rs2_e, rd_m, rd_w, regwrite_m, regwrite_w);

    assign stall_f = ~reset & rawStallD;
    assign stall_d = ~reset & rawStallD;
    assign stall_e = ~reset & miss;
    assign stall_m = ~reset & miss;
    assign flush_d = ~reset & pcsrc_e;
    assign flush_e = ~reset & ((ldStall & ~miss) | pcsrc_e);

    assign pending = pendingVec;

    always_ff @(posedge clk) begin
        if (reset) begin
            stallCyclesReg <= '0;
        end else if (stall_d && stallCyclesReg != '1) begin
            stallCyclesReg <= stallCyclesReg + SCW'(1);
        end
    end

    assign stall_cycles = stallCyclesReg;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Checks two hazard_scoreboard instances (LD_LAT=1 with a narrow stall counter,
// LD_LAT=3) against a per-register latency model, directed then random.
module tb_hazard_scoreboard;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_m, rd_w;
    logic       is_load_d, regwrite_m, regwrite_w, pcsrc_e, miss;

    logic [1:0]  fwdA1, fwdB1, fwdA3, fwdB3;
    logic        sf1, sd1, se1, sm1, fd1, fe1;
    logic        sf3, sd3, se3, sm3, fd3, fe3;
    logic [31:0] pend1, pend3;
    logic [3:0]  sc1;
    logic [15:0] sc3;

    int checks    = 0;
    int passCount = 0;
    int failCount = 0;

    // Model: cycles remaining until each register's load result is forwardable.
    int mCnt[2][32];
    int mSc[2];
    int lat[2]   = '{1, 3};
    int scMax[2] = '{15, 65535};

    always #5 clk = ~clk;

    hazard_scoreboard #(.NREG(32), .LD_LAT(1), .SCW(4)) dut1 (
        .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .is_load_d(is_load_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_m(rd_m), .rd_w(rd_w),
        .regwrite_m(regwrite_m), .regwrite_w(regwrite_w), .pcsrc_e(pcsrc_e), .miss(miss),
        .fwd_a_e(fwdA1), .fwd_b_e(fwdB1), .stall_f(sf1), .stall_d(sd1), .stall_e(se1),
        .stall_m(sm1), .flush_d(fd1), .flush_e(fe1), .pending(pend1), .stall_cycles(sc1));

    hazard_scoreboard #(.NREG(32), .LD_LAT(3), .SCW(16)) dut3 (
        .clk(clk), .reset(reset), .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
        .is_load_d(is_load_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_m(rd_m), .rd_w(rd_w),
        .regwrite_m(regwrite_m), .regwrite_w(regwrite_w), .pcsrc_e(pcsrc_e), .miss(miss),
        .fwd_a_e(fwdA3), .fwd_b_e(fwdB3), .stall_f(sf3), .stall_d(sd3), .stall_e(se3),
        .stall_m(sm3), .flush_d(fd3), .flush_e(fe3), .pending(pend3), .stall_cycles(sc3));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] fwdRef(input logic [4:0] rs);
        if (reset) return 2'd0;
        if (rs != 0 && regwrite_m && rs == rd_m) return 2'd2;
        if (rs != 0 && regwrite_w && rs == rd_w) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit modelLd(input int k);
        return (rs1_d != 0 && mCnt[k][rs1_d] > 0) || (rs2_d != 0 && mCnt[k][rs2_d] > 0);
    endfunction

    task automatic checkDut(input int k, input string nm, input logic [1:0] fa,
                            input logic [1:0] fb, input logic [5:0] flags,
                            input logic [31:0] pend, input logic [15:0] sc);
        logic [31:0] ev;
        logic [5:0]  ef;
        bit ld;
        for (int r = 0; r < 32; r++) ev[r] = (mCnt[k][r] > 0);
        ld = modelLd(k);
        if (reset) ef = 6'b0;
        else ef = {ld | miss, ld | miss, miss, miss, pcsrc_e, (ld & ~miss) | pcsrc_e};
        chk({nm, ".fwd_a"}, 64'(fa), 64'(fwdRef(rs1_e)));
        chk({nm, ".fwd_b"}, 64'(fb), 64'(fwdRef(rs2_e)));
        chk({nm, ".stall_flush"}, 64'(flags), 64'(ef));
        chk({nm, ".pending"}, 64'(pend), 64'(ev));
        chk({nm, ".stall_cycles"}, 64'(sc), 64'(mSc[k]));
    endtask

    // One clock: check all outputs, cross the edge, advance the model.
    task automatic step();
        bit sd, iss;
        #1;
        checkDut(0, "d1", fwdA1, fwdB1, {sf1, sd1, se1, sm1, fd1, fe1}, pend1, 16'(sc1));
        checkDut(1, "d3", fwdA3, fwdB3, {sf3, sd3, se3, sm3, fd3, fe3}, pend3, sc3);
        $display("t=%0t rst=%0b ld=%0b rd_d=%0d rs1_d=%0d rs2_d=%0d pc=%0b miss=%0b sd1=%0b sd3=%0b",
                 $time, reset, is_load_d, rd_d, rs1_d, rs2_d, pcsrc_e, miss, sd1, sd3);
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                for (int r = 0; r < 32; r++) mCnt[k][r] = 0;
                mSc[k] = 0;
            end else begin
                sd  = modelLd(k) | miss;
                iss = is_load_d && rd_d != 0 && !sd && !pcsrc_e;
                if (sd && mSc[k] < scMax[k]) mSc[k]++;
                if (!miss)
                    for (int r = 0; r < 32; r++) if (mCnt[k][r] > 0) mCnt[k][r]--;
                if (iss) mCnt[k][rd_d] = lat[k];
            end
        end
        @(negedge clk);
    endtask

    task automatic clearInputs();
        {rs1_d, rs2_d, rd_d, rs1_e, rs2_e, rd_m, rd_w} = '0;
        {is_load_d, regwrite_m, regwrite_w, pcsrc_e, miss} = '0;
    endtask

    initial begin
        int scBefore;
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) mCnt[k][r] = 0;
            mSc[k] = 0;
        end
        clearInputs();
        reset = 1'b1;
        @(negedge clk);

        // Reset gates outputs even with hazards present on the inputs.
        miss = 1'b1; rs1_e = 5'd4; rd_m = 5'd4; regwrite_m = 1'b1; pcsrc_e = 1'b1;
        step();
        step();
        clearInputs();
        reset = 1'b0;
        step();

        // Forwarding priority and x0 exclusion.
        rs1_e = 5'd4; rs2_e = 5'd4; rd_m = 5'd4; rd_w = 5'd4;
        regwrite_m = 1'b1; regwrite_w = 1'b1;
        #1; chk("fwd_m_priority", 64'(fwdA1), 64'd2);
        step();
        rd_m = 5'd3;
        step();
        rs1_e = 5'd0; rs2_e = 5'd0; rd_m = 5'd0; rd_w = 5'd0;
        step();
        clearInputs();

        // Load to x5 followed by a dependent instruction.
        is_load_d = 1'b1; rd_d = 5'd5;
        step();
        is_load_d = 1'b0; rd_d = 5'd0; rs1_d = 5'd5;
        scBefore = int'(sc3);
        #1; chk("d1.ld_use_stall", 64'({sd1, fe1}), 64'b11);
        step();
        #1; chk("d1.one_bubble", 64'(sd1), 64'd0);
        step();
        step();
        step();
        chk("d3.stall_delta", 64'(int'(sc3) - scBefore), 64'd3);
        rs1_d = 5'd0; rs1_e = 5'd5; rd_w = 5'd5; regwrite_w = 1'b1;
        #1; chk("d1.fwd_from_w", 64'(fwdA1), 64'd1);
        step();
        clearInputs();

        // Load to x7 with dependent on rs2.
        is_load_d = 1'b1; rd_d = 5'd7;
        step();
        is_load_d = 1'b0; rd_d = 5'd0; rs2_d = 5'd7;
        repeat (4) step();
        clearInputs();

        // Miss freezes the x9 countdown.
        is_load_d = 1'b1; rd_d = 5'd9;
        step();
        is_load_d = 1'b0; rd_d = 5'd0;
        step();
        miss = 1'b1; rs1_d = 5'd9;
        repeat (4) step();
        #1; chk("d3.pending9_frozen", 64'(pend3[9]), 64'd1);
        miss = 1'b0;
        repeat (3) step();
        clearInputs();

        // Redirect squashes a decode-stage load.
        is_load_d = 1'b1; rd_d = 5'd3; pcsrc_e = 1'b1;
        #1; chk("d3.flush_de", 64'({fd3, fe3}), 64'b11);
        step();
        clearInputs();
        #1; chk("d3.pending3", 64'(pend3[3]), 64'd0);
        step();

        // Saturate the 4-bit stall counter.
        miss = 1'b1;
        repeat (20) step();
        chk("d1.sc_saturated", 64'(sc1), 64'd15);
        miss = 1'b0;
        step();

        // Reset while x6 is in flight.
        is_load_d = 1'b1; rd_d = 5'd6;
        step();
        clearInputs();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1; chk("d3.pending_after_reset", 64'(pend3), 64'd0);
        chk("d3.sc_after_reset", 64'(sc3), 64'd0);
        step();

        // Random traffic over a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            reset      = ($urandom_range(0, 99) < 2);
            miss       = ($urandom_range(0, 99) < 10);
            pcsrc_e    = ($urandom_range(0, 99) < 10);
            is_load_d  = ($urandom_range(0, 99) < 40);
            rd_d       = 5'($urandom_range(0, 7));
            rs1_d      = 5'($urandom_range(0, 7));
            rs2_d      = 5'($urandom_range(0, 7));
            rs1_e      = 5'($urandom_range(0, 7));
            rs2_e      = 5'($urandom_range(0, 7));
            rd_m       = 5'($urandom_range(0, 7));
            rd_w       = 5'($urandom_range(0, 7));
            regwrite_m = 1'($urandom_range(0, 1));
            regwrite_w = 1'($urandom_range(0, 1));
            step();
        end

        $display("%0d/%0d checks passed", passCount, checks);
        $finish;
    end

endmodule
